risc_v_mike_instruction_memory_sync: RTL and testbench

Parametrised, synchronous-read instruction memory that replaces the hard-coded combinational ROM. A program port loads the contents at boot; a fetch port then serves the fetch stage.
- Fetch port has a 1-cycle registered-read latency, a stall/hold handshake, and flags misaligned and out-of-range accesses.
- The block sits between the PC register and the decode stage. The program port is driven by the testbench or a boot loader.

---
 rtl/risc_v_mike_pkg.sv | 16 +
 rtl/risc_v_mike_sp_ram_1r1w.sv | 37 +++
 rtl/risc_v_mike_instruction_memory_sync.sv | 107 ++++++++++
 tb/tb_risc_v_mike_instruction_memory_sync.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike core.
package risc_v_mike_pkg;

    localparam int DATA_32_W = 32;
    localparam int PC_ADDR_W = 32;

    typedef logic [PC_ADDR_W-1:0] t_pc_addr;

    localparam logic [DATA_32_W-1:0] NOP_INSTR_C = 32'h00000013;

    typedef enum logic {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } t_imem_state;

endpackage

// File: rtl/risc_v_mike_sp_ram_1r1w.sv
// Generic RAM: synchronous write, registered read that holds its value while
// the read enable is low.
module risc_v_mike_sp_ram_1r1w
    import risc_v_mike_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     waddr_i,
    input  logic [DATA_32_W-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [IDX_W-1:0]     raddr_i,
    output logic [DATA_32_W-1:0] rdata_o
);

    logic [DATA_32_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_32_W-1:0] rdata_q;

    // Write port: storage is deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: capture on enable, otherwise hold the last word.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/risc_v_mike_instruction_memory_sync.sv
// Synchronous-read instruction memory with a boot-time program port and a
// 1-cycle-latency fetch port (stall hold, flush on reprogram, error flags).
module risc_v_mike_instruction_memory_sync
    import risc_v_mike_pkg::*;
#(
    parameter int                   MEM_DEPTH = 1024,
    parameter int                   IDX_W     = $clog2(MEM_DEPTH),
    parameter logic [DATA_32_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_start,
    input  logic                 prog_we,
    input  logic [IDX_W-1:0]     prog_addr,
    input  logic [DATA_32_W-1:0] prog_wdata,
    input  logic                 prog_done,
    output logic                 prog_err,
    output logic                 mem_ready,
    input  logic                 fetch_req,
    input  t_pc_addr             fetch_addr,
    input  logic                 fetch_stall,
    output logic                 fetch_valid,
    output logic [DATA_32_W-1:0] fetch_instr,
    output logic                 fetch_err
);

    t_imem_state          state_q, state_d;
    logic                 prog_err_q, prog_err_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 ram_we, ram_re;
    logic                 addr_err;
    logic [PC_ADDR_W-1:0] word_idx;
    logic [DATA_32_W-1:0] ram_rdata;

    // Full shifted index is compared so high address bits can never alias.
    assign word_idx = {2'b00, fetch_addr[PC_ADDR_W-1:2]};
    assign addr_err = (fetch_addr[1:0] != 2'b00) || (word_idx >= PC_ADDR_W'(MEM_DEPTH));

    // Next-state, error flag and fetch pipeline control.
    always_comb begin
        state_d    = state_q;
        prog_err_d = prog_err_q;
        valid_d    = valid_q;
        err_d      = err_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        if (state_q == IMEM_LOAD) begin
            ram_we  = prog_we;
            valid_d = 1'b0;
            err_d   = 1'b0;
            if (prog_done) begin
                state_d = IMEM_RUN;
            end
        end else begin
            if (prog_we) begin
                prog_err_d = 1'b1;
            end
            if (prog_start) begin
                // Flush wins over stall so no stale word leaks past a reprogram.
                state_d = IMEM_LOAD;
                valid_d = 1'b0;
                err_d   = 1'b0;
            end else if (!fetch_stall) begin
                ram_re  = fetch_req;
                valid_d = fetch_req;
                err_d   = fetch_req && addr_err;
            end
        end
    end

    // State and fetch output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IMEM_LOAD;
            prog_err_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_err_q <= prog_err_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    risc_v_mike_sp_ram_1r1w #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_wdata),
        .re_i    (ram_re),
        .raddr_i (fetch_addr[IDX_W+1:2]),
        .rdata_o (ram_rdata)
    );

    // The RAM read register is unreset; gating by valid/err yields NOP after reset or flush.
    assign fetch_instr = (valid_q && !err_q) ? ram_rdata : NOP_INSTR;
    assign fetch_valid = valid_q;
    assign fetch_err   = err_q;
    assign prog_err    = prog_err_q;
    assign mem_ready   = (state_q == IMEM_RUN);

endmodule

// File: tb/tb_risc_v_mike_instruction_memory_sync.sv
// Directed bench for the synchronous instruction memory.
module tb_risc_v_mike_instruction_memory_sync;
    import risc_v_mike_pkg::*;

    localparam int          MEM_DEPTH = 1024;
    localparam int          IDX_W     = 10;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_start;
    logic              prog_we;
    logic [IDX_W-1:0]  prog_addr;
    logic [31:0]       prog_wdata;
    logic              prog_done;
    logic              prog_err;
    logic              mem_ready;
    logic              fetch_req;
    t_pc_addr          fetch_addr;
    logic              fetch_stall;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              fetch_err;

    int n_checks = 0;
    int n_pass   = 0;

    risc_v_mike_instruction_memory_sync #(
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_start  (prog_start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .prog_done   (prog_done),
        .prog_err    (prog_err),
        .mem_ready   (mem_ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_fetch(input string tag, input logic v, input logic e, input logic [31:0] instr);
        check({tag, "_valid"}, {31'd0, fetch_valid}, {31'd0, v});
        check({tag, "_err"},   {31'd0, fetch_err},   {31'd0, e});
        check({tag, "_instr"}, fetch_instr, instr);
    endtask

    task automatic load_word(input logic [IDX_W-1:0] a, input logic [31:0] d, input logic done);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        prog_done  = done;
        tick();
        prog_we    = 1'b0;
        prog_done  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
    endtask

    initial begin
        rst = 1'b1; prog_start = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_wdata = '0; prog_done = 1'b0; fetch_req = 1'b0;
        fetch_addr = '0; fetch_stall = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_perr",  {31'd0, prog_err},  32'd0);
        check_fetch("rst", 1'b0, 1'b0, NOP);

        // prog_start in LOAD is ignored
        prog_start = 1'b1; tick(); prog_start = 1'b0;
        check("load_ignore_start", {31'd0, mem_ready}, 32'd0);

        load_word(10'd0,    32'hffff0437, 1'b0);
        load_word(10'd1,    32'h7ffff137, 1'b0);
        load_word(10'd2,    32'hffc10113, 1'b0);
        load_word(10'd3,    32'hfff00313, 1'b0);
        load_word(10'd1023, 32'hdeadbeef, 1'b1);  // write together with done
        check("run_ready", {31'd0, mem_ready}, 32'd1);

        // prog_done in RUN is ignored
        prog_done = 1'b1; tick(); prog_done = 1'b0;
        check("run_ignore_done", {31'd0, mem_ready}, 32'd1);

        fetch(32'h0); check_fetch("b2b0", 1'b1, 1'b0, 32'hffff0437);
        fetch(32'h4); check_fetch("b2b1", 1'b1, 1'b0, 32'h7ffff137);
        fetch(32'h8); check_fetch("b2b2", 1'b1, 1'b0, 32'hffc10113);
        fetch(32'hC); check_fetch("b2b3", 1'b1, 1'b0, 32'hfff00313);

        fetch(32'h6);        check_fetch("misalign", 1'b1, 1'b1, NOP);
        fetch(32'h1000);     check_fetch("oor",      1'b1, 1'b1, NOP);
        fetch(32'hFFFF_FFFC); check_fetch("oor_hi",  1'b1, 1'b1, NOP);
        fetch(32'hFFC);      check_fetch("last",     1'b1, 1'b0, 32'hdeadbeef);

        fetch_req = 1'b0; tick();
        check_fetch("idle", 1'b0, 1'b0, NOP);

        // Stall holds the 0x4 result while the address moves on
        fetch(32'h4); check_fetch("pre_stall", 1'b1, 1'b0, 32'h7ffff137);
        fetch_stall = 1'b1; fetch_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fetch("stall", 1'b1, 1'b0, 32'h7ffff137);
        end
        fetch_stall = 1'b0; tick();
        check_fetch("release", 1'b1, 1'b0, 32'hffc10113);

        // Illegal write in RUN
        fetch_req = 1'b0;
        load_word(10'd0, 32'h0000_0000, 1'b0);
        check("prog_err_set", {31'd0, prog_err}, 32'd1);
        fetch(32'h0); check_fetch("no_write", 1'b1, 1'b0, 32'hffff0437);

        // Flush over stall
        fetch(32'h8); check_fetch("inflight", 1'b1, 1'b0, 32'hffc10113);
        prog_start = 1'b1; fetch_stall = 1'b1; tick();
        prog_start = 1'b0; fetch_stall = 1'b0;
        check_fetch("flush", 1'b0, 1'b0, NOP);
        check("flush_ready", {31'd0, mem_ready}, 32'd0);

        // Fetch ignored in LOAD, error stays sticky
        fetch(32'h0); check_fetch("load_gate", 1'b0, 1'b0, NOP);
        fetch_req = 1'b0;
        check("prog_err_sticky", {31'd0, prog_err}, 32'd1);

        // Write, then reset mid-load
        load_word(10'd2, 32'h12345678, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_perr",  {31'd0, prog_err},  32'd0);
        check("rst2_ready", {31'd0, mem_ready}, 32'd0);
        prog_done = 1'b1; tick(); prog_done = 1'b0;
        check("rst2_run", {31'd0, mem_ready}, 32'd1);
        fetch(32'h8); check_fetch("survive2", 1'b1, 1'b0, 32'h12345678);
        fetch(32'h0); check_fetch("survive0", 1'b1, 1'b0, 32'hffff0437);
        fetch_req = 1'b0; tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
